// File: rtl/gemm_tile_sequencer_if.sv
// Control bus between the system controller, the tile sequencer and the
// systolic datapath: descriptor/handshake plus buffer and array controls.
interface gemm_tile_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ARRAY_N    = 16
);
  localparam int unsigned DIM_W = $clog2(ARRAY_N) + 1;

  // Descriptor and handshake
  logic                  start;
  logic                  abort;
  logic [31:0]           cfg_m;
  logic [31:0]           cfg_k;
  logic [31:0]           cfg_n;
  logic [ADDR_WIDTH-1:0] cfg_a_base;
  logic [ADDR_WIDTH-1:0] cfg_w_base;
  logic [ADDR_WIDTH-1:0] cfg_o_base;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [2:0]            phase;

  // Datapath controls
  logic                  a_buf_on;
  logic [ADDR_WIDTH-1:0] a_base_addr;
  logic [DIM_W-1:0]      a_num_rows;
  logic                  mode;
  logic                  w_buf_on;
  logic [ADDR_WIDTH-1:0] w_base_addr;
  logic [DIM_W-1:0]      w_num_cols;
  logic [2:0]            operation_signal;
  logic                  o_ag_o_on;
  logic [ADDR_WIDTH-1:0] o_base_addr;

  modport master (
    output start, abort, cfg_m, cfg_k, cfg_n, cfg_a_base, cfg_w_base, cfg_o_base,
    input  busy, done, err, phase,
    input  a_buf_on, a_base_addr, a_num_rows, mode, w_buf_on, w_base_addr,
           w_num_cols, operation_signal, o_ag_o_on, o_base_addr
  );

  modport slave (
    input  start, abort, cfg_m, cfg_k, cfg_n, cfg_a_base, cfg_w_base, cfg_o_base,
    output busy, done, err, phase,
    output a_buf_on, a_base_addr, a_num_rows, mode, w_buf_on, w_base_addr,
           w_num_cols, operation_signal, o_ag_o_on, o_base_addr
  );
endinterface

// File: rtl/gemm_tile_sequencer.sv
// Control FSM for one weight-stationary GEMM tile: validates a descriptor,
// preloads K weight rows, then streams M activation rows through the array
// and drains the skewed outputs. All outputs are registered.
module gemm_tile_sequencer #(
  parameter int unsigned ARRAY_N    = 16,
  parameter int unsigned ARRAY_M    = 16,
  parameter int unsigned MAX_M      = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input logic                  clk,
  input logic                  reset,
  gemm_tile_sequencer_if.slave bus
);
  localparam int unsigned DIM_W = $clog2(ARRAY_N) + 1;

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_LOAD_WGT = 3'b001;
  localparam logic [2:0] OP_COMPUTE  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;

  logic [CNT_WIDTH-1:0]  m_q;
  logic [DIM_W-1:0]      k_q;
  logic [DIM_W-1:0]      n_q;
  logic [ADDR_WIDTH-1:0] a_base_q, w_base_q, o_base_q;

  logic                  capture;
  logic                  cfg_ok;
  logic [CNT_WIDTH-1:0]  k_last;
  logic [CNT_WIDTH-1:0]  l_last;

  logic                  busy_q, done_q, err_q, mode_q, w_on_q, a_on_q, o_on_q;
  logic [2:0]            op_q;
  logic                  busy_n, done_n, err_n, mode_n, w_on_n, a_on_n, o_on_n;
  logic [2:0]            op_n;

  // Descriptor is sampled only from IDLE; limits are checked on the full 32 bits
  assign capture = (state == S_IDLE) && bus.start;
  assign cfg_ok  = (bus.cfg_m != 32'd0) && (bus.cfg_m <= 32'(MAX_M)) &&
                   (bus.cfg_k != 32'd0) && (bus.cfg_k <= 32'(ARRAY_N)) &&
                   (bus.cfg_n != 32'd0) && (bus.cfg_n <= 32'(ARRAY_M));

  // Last counter value of the weight-load and compute phases
  assign k_last = CNT_WIDTH'(k_q) - CNT_WIDTH'(1);
  assign l_last = m_q + CNT_WIDTH'(ARRAY_N + ARRAY_M) - CNT_WIDTH'(1);

  // State and phase-counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, next counter and the next value of every registered output
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    mode_n  = 1'b0;
    w_on_n  = 1'b0;
    a_on_n  = 1'b0;
    o_on_n  = 1'b0;
    op_n    = OP_NOP;

    case (state)
      S_IDLE:    if (bus.start) state_n = cfg_ok ? S_LOAD_W : S_ERR;
      S_LOAD_W:  if (cnt == k_last) state_n = S_COMPUTE;
      S_COMPUTE: if (cnt == l_last) state_n = S_DONE;
      S_ERR:     state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase

    if (bus.abort && (state != S_IDLE)) state_n = S_IDLE;

    if ((state_n != state) || (state_n == S_IDLE)) cnt_n = '0;
    else                                           cnt_n = cnt + CNT_WIDTH'(1);

    busy_n = (state_n != S_IDLE);
    case (state_n)
      S_LOAD_W: begin
        mode_n = 1'b1;
        w_on_n = 1'b1;
        op_n   = OP_LOAD_WGT;
      end
      S_COMPUTE: begin
        op_n   = OP_COMPUTE;
        a_on_n = (cnt_n < m_q);
        // Output window covers column skew plus the SIMD register stage
        o_on_n = (cnt_n >= CNT_WIDTH'(ARRAY_N + 1)) && (cnt_n <= l_last);
      end
      S_DONE: begin
        done_n = 1'b1;
        err_n  = (state == S_ERR);
      end
      default: ;
    endcase
  end

  // Latched descriptor fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      a_base_q <= '0;
      w_base_q <= '0;
      o_base_q <= '0;
    end else if (capture) begin
      m_q      <= CNT_WIDTH'(bus.cfg_m);
      k_q      <= DIM_W'(bus.cfg_k);
      n_q      <= DIM_W'(bus.cfg_n);
      a_base_q <= bus.cfg_a_base;
      w_base_q <= bus.cfg_w_base;
      o_base_q <= bus.cfg_o_base;
    end
  end

  // Registered control outputs, aligned with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= 1'b0;
      w_on_q <= 1'b0;
      a_on_q <= 1'b0;
      o_on_q <= 1'b0;
      op_q   <= OP_NOP;
    end else begin
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
      mode_q <= mode_n;
      w_on_q <= w_on_n;
      a_on_q <= a_on_n;
      o_on_q <= o_on_n;
      op_q   <= op_n;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.phase            = state;
  assign bus.a_buf_on         = a_on_q;
  assign bus.a_base_addr      = a_base_q;
  assign bus.a_num_rows       = k_q;
  assign bus.mode             = mode_q;
  assign bus.w_buf_on         = w_on_q;
  assign bus.w_base_addr      = w_base_q;
  assign bus.w_num_cols       = n_q;
  assign bus.operation_signal = op_q;
  assign bus.o_ag_o_on        = o_on_q;
  assign bus.o_base_addr      = o_base_q;
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: cycle-by-cycle checks of the control
// outputs against hand-computed phase windows.
module tb_gemm_tile_sequencer;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  gemm_tile_sequencer_if #(.ADDR_WIDTH(AW), .ARRAY_N(16)) bus ();

  gemm_tile_sequencer #(
    .ARRAY_N(16), .ARRAY_M(16), .MAX_M(1024), .ADDR_WIDTH(AW), .CNT_WIDTH(12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {busy,done,err,phase,mode,w_buf_on,a_buf_on,o_ag_o_on,op}
  function automatic logic [12:0] pack(input logic b, input logic d, input logic e,
                                       input logic [2:0] ph, input logic md,
                                       input logic w, input logic a, input logic o,
                                       input logic [2:0] op);
    return {b, d, e, ph, md, w, a, o, op};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.busy, bus.done, bus.err, bus.phase, bus.mode, bus.w_buf_on,
            bus.a_buf_on, bus.o_ag_o_on, bus.operation_signal};
  endfunction

  function automatic logic [31:0] obs_addr();
    return 32'({bus.a_base_addr, bus.w_base_addr, bus.o_base_addr});
  endfunction

  function automatic logic [31:0] obs_dim();
    return 32'({bus.a_num_rows, bus.w_num_cols});
  endfunction

  function automatic logic [31:0] addr3(input int a, input int w, input int o);
    return 32'({10'(a), 10'(w), 10'(o)});
  endfunction

  function automatic logic [31:0] dim2(input int k, input int n);
    return 32'({5'(k), 5'(n)});
  endfunction

  // Expected controls at cycle t (start at 0) from hand-computed window edges
  function automatic logic [12:0] exp_tile(input int t, input int k, input int af, input int al,
                                           input int of, input int ol, input int dc);
    if (t >= 1 && t <= k) return pack(1, 0, 0, 3'd1, 1, 1, 0, 0, 3'b001);
    if (t > k && t < dc)
      return pack(1, 0, 0, 3'd2, 0, 0, (t >= af && t <= al), (t >= of && t <= ol), 3'b010);
    if (t == dc) return pack(1, 1, 0, 3'd3, 0, 0, 0, 0, 3'b000);
    return '0;
  endfunction

  task automatic set_cfg(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n,
                         input int a, input int w, input int o);
    bus.cfg_m      = m;
    bus.cfg_k      = k;
    bus.cfg_n      = n;
    bus.cfg_a_base = AW'(a);
    bus.cfg_w_base = AW'(w);
    bus.cfg_o_base = AW'(o);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bad_m [5];
  logic [31:0] bad_k [5];
  logic [31:0] bad_n [5];

  initial begin
    bad_m[0] = 32'd16;   bad_k[0] = 32'd17;     bad_n[0] = 32'd16;
    bad_m[1] = 32'd16;   bad_k[1] = 32'd16;     bad_n[1] = 32'd0;
    bad_m[2] = 32'd0;    bad_k[2] = 32'd16;     bad_n[2] = 32'd16;
    bad_m[3] = 32'd1025; bad_k[3] = 32'd16;     bad_n[3] = 32'd16;
    bad_m[4] = 32'd16;   bad_k[4] = 32'h110;    bad_n[4] = 32'd16;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #10;
    check("reset_ctl", 32'(obs()), 32'd0);
    check("reset_addr", obs_addr(), 32'd0);
    check("reset_dim", obs_dim(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Full 16x16x16 tile with start held high and cfg changed mid-tile,
    // then a back-to-back 3x2x5 tile accepted in the first IDLE cycle
    set_cfg(16, 16, 16, 1, 2, 3);
    bus.start = 1'b1;
    for (int t = 1; t <= 105; t++) begin
      step();
      if (t <= 66) check($sformatf("full@%0d", t), 32'(obs()), 32'(exp_tile(t, 16, 17, 32, 34, 64, 65)));
      else         check($sformatf("b2b@%0d", t), 32'(obs()), 32'(exp_tile(t - 66, 2, 3, 5, 20, 37, 38)));
      if (t == 1 || t == 60) begin
        check($sformatf("full_addr@%0d", t), obs_addr(), addr3(1, 2, 3));
        check($sformatf("full_dim@%0d", t), obs_dim(), dim2(16, 16));
      end
      if (t == 67 || t == 100) begin
        check($sformatf("b2b_addr@%0d", t), obs_addr(), addr3(7, 8, 9));
        check($sformatf("b2b_dim@%0d", t), obs_dim(), dim2(2, 5));
      end
      if (t == 1) set_cfg(3, 2, 5, 7, 8, 9);
      if (t == 67) bus.start = 1'b0;
    end

    // Rejected descriptors: ERR for one cycle, then DONE with err
    for (int i = 0; i < 5; i++) begin
      set_cfg(bad_m[i], bad_k[i], bad_n[i], 11, 12, 13);
      bus.start = 1'b1;
      for (int t = 1; t <= 3; t++) begin
        step();
        if (t == 1) bus.start = 1'b0;
        case (t)
          1:       check($sformatf("inv%0d@1", i), 32'(obs()), 32'(pack(1, 0, 0, 3'd4, 0, 0, 0, 0, 3'b000)));
          2:       check($sformatf("inv%0d@2", i), 32'(obs()), 32'(pack(1, 1, 1, 3'd3, 0, 0, 0, 0, 3'b000)));
          default: check($sformatf("inv%0d@3", i), 32'(obs()), 32'd0);
        endcase
      end
    end

    // Abort at cycle 10; start and abort together in IDLE; abort in LOAD_W
    set_cfg(16, 16, 16, 4, 5, 6);
    bus.start = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      step();
      if (t <= 10)      check($sformatf("abort@%0d", t), 32'(obs()), 32'(exp_tile(t, 16, 17, 32, 34, 64, 65)));
      else if (t == 13) check("abort@13", 32'(obs()), 32'(exp_tile(1, 16, 17, 32, 34, 64, 65)));
      else              check($sformatf("abort@%0d", t), 32'(obs()), 32'd0);
      case (t)
        1:  bus.start = 1'b0;
        10: bus.abort = 1'b1;
        11: bus.abort = 1'b0;
        12: begin bus.start = 1'b1; bus.abort = 1'b1; end
        13: bus.start = 1'b0;
        14: bus.abort = 1'b0;
        default: ;
      endcase
    end

    // Largest legal tile: M=1024, K=1, N=1
    set_cfg(1024, 1, 1, 20, 21, 22);
    bus.start = 1'b1;
    for (int t = 1; t <= 1059; t++) begin
      step();
      if (t == 1) begin
        bus.start = 1'b0;
        check("max_dim", obs_dim(), dim2(1, 1));
      end
      check($sformatf("max@%0d", t), 32'(obs()), 32'(exp_tile(t, 1, 2, 1025, 19, 1057, 1058)));
    end

    // Asynchronous reset in the middle of COMPUTE
    set_cfg(3, 2, 5, 7, 8, 9);
    bus.start = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (t == 1) bus.start = 1'b0;
      check($sformatf("rst_run@%0d", t), 32'(obs()), 32'(exp_tile(t, 2, 3, 5, 20, 37, 38)));
    end
    #2 reset = 1'b0;
    #1;
    check("async_rst_ctl", 32'(obs()), 32'd0);
    check("async_rst_addr", obs_addr(), 32'd0);
    check("async_rst_dim", obs_dim(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      check($sformatf("post_rst@%0d", t), 32'(obs()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
